image_sequencer: RTL and testbench
==================================

Name: image_sequencer

Overview:
- Screensaver pattern scheduler: owns the global `frame` counter fed to all image generator instances.
- Selects which of NUM_PATTERNS generators drives the VGA colour outputs.
- Cross-fades between patterns by brightness ramp (fade out, swap, fade in).
- Sits between the generator bank and the VGA output stage, clocked by the pixel clock.

Parameters:
- NUM_PATTERNS, 2, number of generator inputs; legal range 2..8.
- HOLD_FRAMES, 600, frames a pattern is shown at full brightness before a transition; legal range ≥1.
- FADE_STEP, 2, frames per brightness step during fades; legal range ≥1.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- position_x_NEXT  in  10  next-pixel x coordinate from the VGA timing block.
- position_y_NEXT  in  9  next-pixel y coordinate.
- pattern_rgb  in  12*NUM_PATTERNS  registered generator outputs; slice k = {r,g,b} of pattern k, r in the MSBs.
- skip_req  in  1  request an early transition; level-held until acknowledged.
- skip_ack  out  1  one-cycle pulse when skip_req is accepted.
- frame  out  32  frame counter broadcast to generators.
- select  out  3  index of the currently displayed pattern.
- level  out  5  current brightness, 0..16.
- busy  out  1  high in any state other than HOLD.
- r, g, b  out  4 each  scaled colour output.

Behaviour:
- Reset values: frame=0, select=0, level=16, state=HOLD, hold counter=0, step counter=0, skip_ack=0, busy=0.
- Frame-start pulse: asserted for one cycle when position_x_NEXT==0 && position_y_NEXT==0 and the same condition was false on the previous cycle.
  - The previous-cycle flag resets to 1, so no pulse is generated on the first cycle after reset.
- All state, counter, select and level updates occur only on frame-start cycles. skip_ack is the only exception.
- frame increments by 1 on each frame start and wraps 2^32-1 to 0.
- FSM states: HOLD, FADE_OUT, SWAP, FADE_IN.
- HOLD:
  - level=16.
  - Hold counter increments each frame start.
  - When the counter reaches HOLD_FRAMES-1 on a frame start, go to FADE_OUT and clear the counter.
- skip_req:
  - Sampled in HOLD on any cycle. skip_ack pulses on the first such cycle.
  - Sets an internal pending flag; the pending flag forces the transition to FADE_OUT on the next frame start.
  - skip_req outside HOLD: no ack; the request stays pending in the requester.
- FADE_OUT:
  - Step counter counts frame starts.
  - Every FADE_STEP frame starts, level decrements by 1.
  - The frame start that takes level to 0 also moves to SWAP.
- SWAP:
  - Lasts exactly one frame at level 0.
  - On the next frame start, select advances by 1, wrapping NUM_PATTERNS-1 to 0; go to FADE_IN.
- FADE_IN:
  - level increments by 1 every FADE_STEP frame starts.
  - The frame start that takes level to 16 also moves to HOLD with hold counter=0.
- Colour path:
  - Combinational from the registered select and level; no added latency relative to the generators.
  - Each channel: out = (c*level)>>4, computed in 9 bits and truncated to 4.
  - level 16 gives passthrough; level 0 gives black.
- Because select and level change only on frame-start cycles, the image never changes mid-frame.
- rst mid-fade: immediate return to reset values on the next edge.

Optional Feature:
- SEQ_FADE_EN defined:
  - Full four-state behaviour as above.
- SEQ_FADE_EN undefined:
  - FADE_OUT and FADE_IN are not implemented.
  - HOLD expiry or skip goes directly to SWAP.
  - level is constant 16, except 0 during SWAP (one black frame).
  - Multiplier logic is removed.

Decomposition:
- Shared package image_pkg holds:
  - state enum seq_state_t {HOLD, FADE_OUT, SWAP, FADE_IN};
  - LEVEL_MAX=5'd16;
  - the screen constants 640/480.
- One sub-module: image_scale, a combinational 4-bit colour × 5-bit level scaler. Instantiated three times.

Test Plan:
All scenarios use NUM_PATTERNS=2, HOLD_FRAMES=4, FADE_STEP=1, pattern0=12'hFFF, pattern1=12'h8F0, with frames driven by a fast coordinate sweep.
- Reset/pulse: rst held 3 cycles, then coordinates at (0,0) -> no frame increment on that cycle; first increment after coordinates leave and return to (0,0).
- Hold expiry: after 4 frame starts -> busy=1, level=15. Over the following frames level runs 15…0, then one SWAP frame, then select=1, then level 1…16, then busy=0. r/g/b at level 8 = 4'h7,4'h7,4'h7 for pattern0.
- Wrap: second full cycle -> select returns 1→0.
- Skip: skip_req at hold count 1 -> skip_ack one-cycle pulse; FADE_OUT begins at the next frame start. skip_req held in FADE_IN -> no ack until HOLD.
- Reset mid-fade: rst while level=5 -> level=16, select=0, frame=0 next cycle.
- SEQ_FADE_EN undefined: after 4 frames -> level=0 for exactly one frame, then select=1, level=16.

Source files
------------

// File: rtl/image_pkg.sv
// Shared types and constants for the screensaver pattern sequencer.
// Optional cross-fade is compiled in with SEQ_FADE_EN.
package image_pkg;
  typedef enum logic [1:0] {HOLD, FADE_OUT, SWAP, FADE_IN} seq_state_t;

  localparam logic [4:0] LEVEL_MAX = 5'd16;
  localparam int         H_RES     = 640;
  localparam int         V_RES     = 480;
  localparam int         RGB_W     = 12;
endpackage

// File: rtl/image_scale.sv
// One colour channel scaled by brightness level 0..16.
// With SEQ_FADE_EN: out = (c*level)>>4. Without it, level is only ever
// 0 or 16, so a simple gate replaces the multiplier.
module image_scale (
  input  logic [3:0] c,
  input  logic [4:0] level,
  output logic [3:0] out
);
`ifdef SEQ_FADE_EN
  logic [8:0] prod;
  assign prod = {5'd0, c} * {4'd0, level};
  assign out  = 4'(prod >> 4);
`else
  assign out  = (level == 5'd0) ? 4'd0 : c;
`endif
endmodule

// File: rtl/image_sequencer.sv
// Screensaver pattern scheduler: frame counter, pattern select, and
// brightness cross-fade (fade out, swap, fade in) between generators.
// SEQ_FADE_EN enables the fade ramps; without it a transition is a single
// black SWAP frame.
module image_sequencer
  import image_pkg::*;
#(
  parameter int NUM_PATTERNS = 2,
  parameter int HOLD_FRAMES  = 600,
  parameter int FADE_STEP    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                position_x_NEXT,
  input  logic [8:0]                position_y_NEXT,
  input  logic [RGB_W*NUM_PATTERNS-1:0] pattern_rgb,
  input  logic                      skip_req,
  output logic                      skip_ack,
  output logic [31:0]               frame,
  output logic [2:0]                select,
  output logic [4:0]                level,
  output logic                      busy,
  output logic [3:0]                r,
  output logic [3:0]                g,
  output logic [3:0]                b
);
  localparam int HCW = $clog2(HOLD_FRAMES + 1);

  seq_state_t      state;
  logic [HCW-1:0]  hold_cnt;
  logic            prev_origin;
  logic            pending;

  logic at_origin, fs, hold_done, leave_hold, accept;
  logic [2:0] sel_next;

  assign at_origin  = (position_x_NEXT == 10'd0) && (position_y_NEXT == 9'd0);
  assign fs         = at_origin && !prev_origin;
  assign hold_done  = (hold_cnt == HCW'(HOLD_FRAMES - 1));
  assign leave_hold = (state == HOLD) && fs && (hold_done || pending);
  // A skip arriving on the very frame start that already leaves HOLD is not
  // acknowledged; the requester keeps it pending for the next HOLD.
  assign accept     = (state == HOLD) && skip_req && !pending && !leave_hold;
  assign sel_next   = (select == 3'(NUM_PATTERNS - 1)) ? 3'd0 : select + 3'd1;
  assign busy       = (state != HOLD);

`ifdef SEQ_FADE_EN
  localparam int SCW = $clog2(FADE_STEP + 1);
  logic [SCW-1:0] step_cnt;
  logic           step_hit;
  logic [4:0]     lvl_dn, lvl_up;

  // The frame start that leaves HOLD/SWAP counts as the first fade step,
  // so with FADE_STEP=1 the level moves on that same frame start.
  assign step_hit = (step_cnt == SCW'(FADE_STEP - 1));
  assign lvl_dn   = level - 5'd1;
  assign lvl_up   = level + 5'd1;
`endif

  // Sequencer FSM, counters, and frame-start detection
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      prev_origin <= 1'b1;
      pending     <= 1'b0;
      skip_ack    <= 1'b0;
      frame       <= 32'd0;
      select      <= 3'd0;
      level       <= LEVEL_MAX;
`ifdef SEQ_FADE_EN
      step_cnt    <= '0;
`endif
    end else begin
      prev_origin <= at_origin;
      skip_ack    <= accept;
      if (accept) pending <= 1'b1;
      if (fs) begin
        frame <= frame + 32'd1;
        case (state)
          HOLD: begin
            if (hold_done || pending) begin
              hold_cnt <= '0;
              pending  <= 1'b0;
`ifdef SEQ_FADE_EN
              state    <= FADE_OUT;
              if (step_hit) begin
                step_cnt <= '0;
                level    <= lvl_dn;
              end else begin
                step_cnt <= step_cnt + 1'b1;
              end
`else
              state    <= SWAP;
              level    <= 5'd0;
`endif
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
`ifdef SEQ_FADE_EN
          FADE_OUT: begin
            if (step_hit) begin
              step_cnt <= '0;
              level    <= lvl_dn;
              if (lvl_dn == 5'd0) state <= SWAP;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
          SWAP: begin
            select <= sel_next;
            state  <= FADE_IN;
            if (step_hit) begin
              step_cnt <= '0;
              level    <= lvl_up;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
          FADE_IN: begin
            if (step_hit) begin
              step_cnt <= '0;
              level    <= lvl_up;
              if (lvl_up == LEVEL_MAX) begin
                state    <= HOLD;
                hold_cnt <= '0;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
`else
          SWAP: begin
            select <= sel_next;
            state  <= HOLD;
            level  <= LEVEL_MAX;
          end
`endif
          default: state <= HOLD;
        endcase
      end
    end
  end

  logic [NUM_PATTERNS-1:0][RGB_W-1:0] pat;
  logic [RGB_W-1:0]                   cur;
  logic [2:0][3:0]                    chan;

  assign pat = pattern_rgb;

  // Pattern mux on the registered select; no added latency
  always_comb begin
    cur = '0;
    for (int k = 0; k < NUM_PATTERNS; k++)
      if (select == 3'(k)) cur = pat[k];
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_scale
    image_scale u_scale (
      .c     (cur[11-4*ch -: 4]),
      .level (level),
      .out   (chan[ch])
    );
  end

  assign r = chan[0];
  assign g = chan[1];
  assign b = chan[2];
endmodule

// File: tb/tb_image_sequencer.sv
// Directed bench for image_sequencer: NUM_PATTERNS=2, HOLD_FRAMES=4,
// FADE_STEP=1, frames produced by a two-cycle coordinate sweep.
// Covers the SEQ_FADE_EN build and the default (no fade) build.
module tb_image_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [23:0] pat;
  logic        skip_req;
  logic        skip_ack;
  logic [31:0] frame;
  logic [2:0]  select;
  logic [4:0]  level;
  logic        busy;
  logic [3:0]  r, g, b;

  int vecs = 0;
  int errs = 0;
  int fexp = 0;

  image_sequencer #(.NUM_PATTERNS(2), .HOLD_FRAMES(4), .FADE_STEP(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .position_x_NEXT (x),
    .position_y_NEXT (y),
    .pattern_rgb     (pat),
    .skip_req        (skip_req),
    .skip_ack        (skip_ack),
    .frame           (frame),
    .select          (select),
    .level           (level),
    .busy            (busy),
    .r               (r),
    .g               (g),
    .b               (b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One frame: leave the origin for a cycle, return to it; the return edge
  // is a frame start. Called and returns on a negedge.
  task automatic fs_tick();
    x = 10'd5;
    @(negedge clk);
    x = 10'd0;
    y = 9'd0;
    @(negedge clk);
    fexp++;
  endtask

  initial begin
    rst      = 1'b1;
    x        = 10'd0;
    y        = 9'd0;
    skip_req = 1'b0;
    pat      = {12'h8F0, 12'hFFF};
    repeat (3) @(negedge clk);
    check("rst_frame",  frame,    32'd0);
    check("rst_select", {29'd0, select}, 32'd0);
    check("rst_level",  {27'd0, level},  32'd16);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_ack",    {31'd0, skip_ack}, 32'd0);
    check("rst_rgb",    {20'd0, r, g, b}, 32'hFFF);

    rst = 1'b0;
    @(negedge clk);
    check("no_pulse_after_rst", frame, 32'd0);
    fs_tick();
    check("first_frame", frame, 32'd1);

`ifdef SEQ_FADE_EN
    repeat (3) fs_tick();
    check("expire_busy",  {31'd0, busy},  32'd1);
    check("expire_level", {27'd0, level}, 32'd15);
    for (int i = 14; i >= 0; i--) begin
      fs_tick();
      check("fade_out_level", {27'd0, level}, 32'(i));
      if (i == 8) check("rgb_lvl8", {20'd0, r, g, b}, 32'h777);
    end
    check("swap_busy",   {31'd0, busy},   32'd1);
    check("swap_select", {29'd0, select}, 32'd0);
    fs_tick();
    check("fade_in_select", {29'd0, select}, 32'd1);
    check("fade_in_first",  {27'd0, level},  32'd1);
    for (int i = 2; i <= 16; i++) begin
      fs_tick();
      check("fade_in_level", {27'd0, level}, 32'(i));
    end
    check("hold_busy", {31'd0, busy}, 32'd0);
    check("rgb_pat1",  {20'd0, r, g, b}, 32'h8F0);
    check("frame_cnt", frame, 32'(fexp));

    // second full cycle wraps select back to 0
    repeat (4) fs_tick();
    check("wrap_fo",  {27'd0, level}, 32'd15);
    repeat (15) fs_tick();
    check("wrap_black", {27'd0, level}, 32'd0);
    fs_tick();
    check("wrap_select", {29'd0, select}, 32'd0);
    check("wrap_level",  {27'd0, level},  32'd1);
    repeat (15) fs_tick();
    check("wrap_hold", {27'd0, level}, 32'd16);
    check("wrap_busy", {31'd0, busy},  32'd0);

    // skip at hold count 1
    fs_tick();
    skip_req = 1'b1;
    @(negedge clk);
    check("skip_ack_hi", {31'd0, skip_ack}, 32'd1);
    skip_req = 1'b0;
    @(negedge clk);
    check("skip_ack_lo", {31'd0, skip_ack}, 32'd0);
    check("skip_wait",   {27'd0, level},    32'd16);
    fs_tick();
    check("skip_fo_level", {27'd0, level}, 32'd15);
    check("skip_fo_busy",  {31'd0, busy},  32'd1);
    repeat (15) fs_tick();
    fs_tick();
    check("skip_sel", {29'd0, select}, 32'd1);
    check("skip_fi",  {27'd0, level},  32'd1);

    // skip held during FADE_IN: no ack until HOLD
    skip_req = 1'b1;
    repeat (14) fs_tick();
    check("fi_no_ack", {31'd0, skip_ack}, 32'd0);
    check("fi_lvl15",  {27'd0, level},    32'd15);
    fs_tick();
    check("fi_hold_no_ack_yet", {31'd0, skip_ack}, 32'd0);
    @(negedge clk);
    check("hold_ack_hi", {31'd0, skip_ack}, 32'd1);
    skip_req = 1'b0;
    @(negedge clk);
    check("hold_ack_lo", {31'd0, skip_ack}, 32'd0);
    fs_tick();
    check("pending_fo", {27'd0, level}, 32'd15);
    repeat (10) fs_tick();
    check("pre_rst_level",  {27'd0, level},  32'd5);
    check("pre_rst_select", {29'd0, select}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_level",  {27'd0, level},  32'd16);
    check("midrst_select", {29'd0, select}, 32'd0);
    check("midrst_frame",  frame,           32'd0);
    check("midrst_busy",   {31'd0, busy},   32'd0);
    rst = 1'b0;
`else
    repeat (2) fs_tick();
    check("hold_level", {27'd0, level}, 32'd16);
    fs_tick();
    check("swap_level", {27'd0, level}, 32'd0);
    check("swap_busy",  {31'd0, busy},  32'd1);
    check("swap_rgb",   {20'd0, r, g, b}, 32'h000);
    check("swap_frame", frame, 32'(fexp));
    fs_tick();
    check("post_select", {29'd0, select}, 32'd1);
    check("post_level",  {27'd0, level},  32'd16);
    check("post_busy",   {31'd0, busy},   32'd0);
    check("post_rgb",    {20'd0, r, g, b}, 32'h8F0);

    repeat (3) fs_tick();
    check("hold2_level", {27'd0, level}, 32'd16);
    fs_tick();
    check("swap2_level", {27'd0, level}, 32'd0);
    fs_tick();
    check("wrap_select", {29'd0, select}, 32'd0);

    // skip at hold count 1
    fs_tick();
    skip_req = 1'b1;
    @(negedge clk);
    check("skip_ack_hi", {31'd0, skip_ack}, 32'd1);
    skip_req = 1'b0;
    @(negedge clk);
    check("skip_ack_lo", {31'd0, skip_ack}, 32'd0);
    check("skip_wait",   {27'd0, level},    32'd16);
    fs_tick();
    check("skip_swap", {27'd0, level}, 32'd0);

    // skip held in SWAP: no ack until HOLD
    skip_req = 1'b1;
    @(negedge clk);
    check("swap_no_ack", {31'd0, skip_ack}, 32'd0);
    fs_tick();
    check("skip_sel", {29'd0, select}, 32'd1);
    @(negedge clk);
    check("hold_ack_hi", {31'd0, skip_ack}, 32'd1);
    skip_req = 1'b0;
    @(negedge clk);
    check("hold_ack_lo", {31'd0, skip_ack}, 32'd0);
    fs_tick();
    check("pending_swap", {27'd0, level}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_level",  {27'd0, level},  32'd16);
    check("midrst_select", {29'd0, select}, 32'd0);
    check("midrst_frame",  frame,           32'd0);
    check("midrst_busy",   {31'd0, busy},   32'd0);
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
